lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the pipeline MEM stage and a word-organised data memory with byte enables.
- Accepts one RV32 load/store per handshake and generates the memory beats.
- Aligns and merges read data, then sign- or zero-extends it for lb/lh/lw/lbu/lhu.
- Splits misaligned halfword/word accesses into two word beats. This split is optional; see Optional Feature.

Parameters:
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: data width. Fixed at 32; other values are unsupported.
- MEM_WORD_AW, 30: memory word-address width (ADDR_WIDTH-2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 load/store funct3.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores.
- rsp_err  out  1  illegal funct3 or unsupported misalignment; valid with rsp_valid.
- mem_req  out  1  memory beat request; held until mem_ack.
- mem_we  out  1  beat is a write.
- mem_addr  out  MEM_WORD_AW  word address.
- mem_be  out  4  byte enables.
- mem_wdata  out  DATA_WIDTH  lane-aligned write data.
- mem_rdata  in  DATA_WIDTH  read data, valid in the mem_ack cycle.
- mem_ack  in  1  beat complete; may be asserted in the same cycle as mem_req.

Behaviour:
- Reset (asynchronous): state=IDLE.
  - req_ready=1.
  - rsp_valid, rsp_err, mem_req, mem_we = 0.
  - mem_addr, mem_be, mem_wdata, rsp_rdata = 0.
  - The merge register is cleared.
  - Reset asserted mid-transaction drops mem_req immediately. The transaction is abandoned and no rsp_valid is produced.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch the request (accept cycle).
  - Legal funct3 for loads: 000, 001, 010, 100, 101. Legal funct3 for stores: 000, 001, 010.
  - Illegal funct3 goes to RESP with err=1 and no memory beat.
  - Otherwise go to BEAT0.
- Lane setup: off = addr[1:0]; size = 1/2/4 bytes from funct3[1:0].
  - Beat 0: be0 = lane mask (size ones) << off, truncated to 4 bits; wdata0 = wdata << 8*off.
  - An access crosses a word when off+size > 4.
- BEAT0:
  - mem_req=1, mem_addr = addr[ADDR_WIDTH-1:2], be=be0, mem_we=req_we.
  - On mem_ack, capture rdata >> 8*off into the merge register.
  - If the access crosses a word, go to BEAT1; otherwise go to RESP.
- BEAT1:
  - mem_addr = word+1, wrapping modulo 2^MEM_WORD_AW.
  - be = mask >> (4-off); wdata = wdata >> 8*(4-off).
  - On mem_ack, OR rdata << 8*(4-off) into the merge register, then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_rdata: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through; stores return 0.
  - Next state is IDLE. req_ready is 0 in RESP, so there is no back-to-back accept.
- Latency, accept to rsp_valid: 2 + total mem wait cycles per beat. With zero-wait ack this is 2 for aligned accesses and 3 for split accesses.
- mem outputs are registered and stable while mem_req=1 and mem_ack=0.
- mem_ack is ignored when mem_req=0.
- req_valid is ignored outside IDLE.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- When defined: crossing accesses use two beats as described above.
- When undefined:
  - Any crossing access goes straight from IDLE to RESP with rsp_err=1 and no mem_req.
  - Non-crossing misaligned halfwords (off=1, off=2) still complete in one beat.
  - The BEAT1 state and its logic are omitted.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_LB/LH/LW/LBU/LHU/SB/SH/SW.
  - State enum lsu_state_t {IDLE, BEAT0, BEAT1, RESP}.
  - Function size_mask(funct3).
- One sub-module, lsu_load_extend: combinational merge-register to rsp_rdata extension. The same function is reused by the writeback mux.

Test Plan:
1. sw addr=0x10, wdata=0xDEADBEEF, zero-wait ack -> one beat: mem_addr=4, be=1111, wdata=0xDEADBEEF. rsp_valid 2 cycles after accept, err=0.
2. lb addr=0x13, mem_rdata=0x80112233 -> be=1000, rsp_rdata=0xFFFFFF80. lbu at the same address -> 0x00000080.
3. lw addr=0x0E (split enabled), beat0 rdata=0xAABB0000, beat1 rdata=0x0000CCDD -> beat0 mem_addr=3, be=1100; beat1 mem_addr=4, be=0011. rsp_rdata=0xCCDDAABB, 3 cycles after accept.
4. sh addr=0x07, wdata=0x1234 (split enabled) -> beat0 be=1000, wdata[31:24]=0x34; beat1 mem_addr=2, be=0001, wdata[7:0]=0x12. The same case with the macro undefined -> rsp_err=1 and no mem_req.
5. Load funct3=011 -> no mem_req, rsp_valid with rsp_err=1 one cycle after accept. mem_ack held low 5 cycles on an lw -> mem_* stable throughout, rsp_valid follows the ack.
6. rst_n asserted while in BEAT1 waiting for ack -> mem_req=0 immediately, no rsp_valid, req_ready=1 after release. A new lh addr=0x2 with rdata=0x8001FFFF then returns 0xFFFF8001.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and lane-mask helpers for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} lsu_state_t;

    // Access size as a right-justified byte mask: 1, 2 or 4 ones.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of right-justified merged load data according to funct3.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] merged,
    output logic [31:0] rdata
);

    always_comb begin
        rdata = merged;
        case (funct3)
            F3_LB:   rdata = {{24{merged[7]}}, merged[7:0]};
            F3_LH:   rdata = {{16{merged[15]}}, merged[15:0]};
            F3_LBU:  rdata = {24'b0, merged[7:0]};
            F3_LHU:  rdata = {16'b0, merged[15:0]};
            default: rdata = merged;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one RV32 access per handshake, issued as one or two word beats.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses; otherwise they return rsp_err.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_WORD_AW = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   rsp_valid,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_err,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [MEM_WORD_AW-1:0] mem_addr,
    output logic [3:0]             mem_be,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack
);

    lsu_state_t state_q, state_d;

    logic                   we_q, err_q;
    logic [2:0]             funct3_q;
    logic [1:0]             off_q;
    logic [DATA_WIDTH-1:0]  merge_q, ext_data;
    logic                   mem_req_q, mem_we_q;
    logic [MEM_WORD_AW-1:0] mem_addr_q;
    logic [3:0]             mem_be_q;
    logic [DATA_WIDTH-1:0]  mem_wdata_q;

    logic [7:0]            be_wide;
    logic [4:0]            req_sh;
    logic [DATA_WIDTH-1:0] wdata_lo;
    logic                  crossing, req_err;

    // Upper nibble of the shifted mask holds the second-word byte enables.
    assign be_wide  = {4'b0, size_mask(req_funct3)} << req_addr[1:0];
    assign req_sh   = {req_addr[1:0], 3'b000};
    assign wdata_lo = req_wdata << req_sh;
    assign crossing = |be_wide[7:4];

`ifdef LSU_MISALIGN_SPLIT_EN
    logic                  cross_q;
    logic [3:0]            be_hi_q;
    logic [DATA_WIDTH-1:0] wdata_hi_q;
    logic [DATA_WIDTH-1:0] wdata_hi;
    assign wdata_hi = req_wdata >> (6'd32 - {1'b0, req_sh});
    assign req_err  = !funct3_legal(req_we, req_funct3);
`else
    assign req_err  = !funct3_legal(req_we, req_funct3) || crossing;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid) state_d = req_err ? RESP : BEAT0;
`ifdef LSU_MISALIGN_SPLIT_EN
            BEAT0: if (mem_ack) state_d = cross_q ? BEAT1 : RESP;
            BEAT1: if (mem_ack) state_d = RESP;
`else
            BEAT0: if (mem_ack) state_d = RESP;
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        case (state_q)
            IDLE: req_ready = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = we_q ? '0 : ext_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            merge_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            cross_q     <= 1'b0;
            be_hi_q     <= '0;
            wdata_hi_q  <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q     <= req_we;
                    err_q    <= req_err;
                    funct3_q <= req_funct3;
                    off_q    <= req_addr[1:0];
                    merge_q  <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    cross_q    <= crossing;
                    be_hi_q    <= be_wide[7:4];
                    wdata_hi_q <= wdata_hi;
`endif
                    if (!req_err) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= req_we;
                        mem_addr_q  <= req_addr[ADDR_WIDTH-1:2];
                        mem_be_q    <= be_wide[3:0];
                        mem_wdata_q <= wdata_lo;
                    end
                end
                BEAT0: if (mem_ack) begin
                    merge_q <= mem_rdata >> {off_q, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (cross_q) begin
                        mem_addr_q  <= mem_addr_q + MEM_WORD_AW'(1);
                        mem_be_q    <= be_hi_q;
                        mem_wdata_q <= wdata_hi_q;
                    end else begin
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_be_q    <= '0;
                        mem_wdata_q <= '0;
                    end
`else
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= '0;
                    mem_wdata_q <= '0;
`endif
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                BEAT1: if (mem_ack) begin
                    merge_q     <= merge_q | (mem_rdata << (6'd32 - {1'b0, off_q, 3'b000}));
                    mem_req_q   <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= '0;
                    mem_wdata_q <= '0;
                end
`endif
                default: ;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

    lsu_load_extend u_extend (
        .funct3 (funct3_q),
        .merged (merge_q),
        .rdata  (ext_data)
    );

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table plus wait-state and reset sequences.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rd0, rd1;
        int          nbeats;
        logic [29:0] a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rd0,
                                input logic [31:0] rd1, input int nb, input logic [29:0] a0,
                                input logic [3:0] be0, input logic [31:0] wd0,
                                input logic [29:0] a1, input logic [3:0] be1,
                                input logic [31:0] wd1, input logic err,
                                input logic [31:0] rdata, input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
        v.nbeats = nb; v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.a1 = a1; v.be1 = be1;
        v.wd1 = wd1; v.err = err; v.rdata = rdata; v.lat = lat;
        return v;
    endfunction

    task automatic accept(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   k;
        bit   done;
        string tag;
        v = vecs[idx];
        tag = $sformatf("v%0d", idx);
        k = 0;
        done = 1'b0;
        accept(v.we, v.f3, v.addr, v.wdata, tag);
        for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
            if (rsp_valid) begin
                chk({tag, " latency"}, 64'(cyc), 64'(v.lat));
                chk({tag, " rsp_err"}, 64'(rsp_err), 64'(v.err));
                chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.rdata));
                chk({tag, " beats"}, 64'(k), 64'(v.nbeats));
                mem_ack = 1'b0;
                done = 1'b1;
            end else begin
                mem_ack = 1'b0;
                if (mem_req) begin
                    if (k >= v.nbeats) begin
                        chk({tag, " extra beat"}, 64'(k), 64'(v.nbeats));
                    end else begin
                        chk($sformatf("%s b%0d mem_we", tag, k), 64'(mem_we), 64'(v.we));
                        chk($sformatf("%s b%0d mem_addr", tag, k), 64'(mem_addr),
                            64'(k == 0 ? v.a0 : v.a1));
                        chk($sformatf("%s b%0d mem_be", tag, k), 64'(mem_be),
                            64'(k == 0 ? v.be0 : v.be1));
                        chk($sformatf("%s b%0d mem_wdata", tag, k), 64'(mem_wdata),
                            64'(k == 0 ? v.wd0 : v.wd1));
                    end
                    mem_rdata = (k == 0) ? v.rd0 : v.rd1;
                    mem_ack = 1'b1;
                    k++;
                end
                @(posedge clk); #1;
            end
        end
        if (!done) chk({tag, " timeout rsp_valid"}, 64'(0), 64'(1));
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    int idx_lh;

    initial begin
        logic [29:0] sa;
        logic [3:0]  sb;
        logic [31:0] sw;
        bit          seen;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

        vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0,
                          1, 30'h4, 4'b1111, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 2));
        vecs.push_back(mk(0, 3'b000, 32'h13, 0, 32'h80112233, 0,
                          1, 30'h4, 4'b1000, 0, 0, 0, 0, 0, 32'hFFFFFF80, 2));
        vecs.push_back(mk(0, 3'b100, 32'h13, 0, 32'h80112233, 0,
                          1, 30'h4, 4'b1000, 0, 0, 0, 0, 0, 32'h00000080, 2));
        vecs.push_back(mk(0, 3'b011, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        vecs.push_back(mk(1, 3'b100, 32'h20, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        vecs.push_back(mk(0, 3'b101, 32'h01, 0, 32'h00ABCD00, 0,
                          1, 30'h0, 4'b0110, 0, 0, 0, 0, 0, 32'h0000ABCD, 2));
        vecs.push_back(mk(1, 3'b000, 32'h05, 32'h000000A5, 0, 0,
                          1, 30'h1, 4'b0010, 32'h0000A500, 0, 0, 0, 0, 32'h0, 2));
        vecs.push_back(mk(0, 3'b001, 32'h02, 0, 32'h8001FFFF, 0,
                          1, 30'h0, 4'b1100, 0, 0, 0, 0, 0, 32'hFFFF8001, 2));
        idx_lh = vecs.size() - 1;
`ifdef LSU_MISALIGN_SPLIT_EN
        vecs.push_back(mk(0, 3'b010, 32'h0E, 0, 32'hAABB0000, 32'h0000CCDD,
                          2, 30'h3, 4'b1100, 0, 30'h4, 4'b0011, 0, 0, 32'hCCDDAABB, 3));
        vecs.push_back(mk(1, 3'b001, 32'h07, 32'h1234, 0, 0,
                          2, 30'h1, 4'b1000, 32'h34000000, 30'h2, 4'b0001, 32'h12,
                          0, 32'h0, 3));
        vecs.push_back(mk(0, 3'b010, 32'hFFFFFFFD, 0, 32'h11223344, 32'h55667788,
                          2, 30'h3FFFFFFF, 4'b1110, 0, 30'h0, 4'b0001, 0, 0, 32'h88112233, 3));
`else
        vecs.push_back(mk(0, 3'b010, 32'h0E, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        vecs.push_back(mk(1, 3'b001, 32'h07, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
        vecs.push_back(mk(0, 3'b010, 32'hFFFFFFFD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 1));
`endif

        #12;
        chk("reset req_ready", 64'(req_ready), 64'd1);
        chk("reset outputs", {rsp_valid, rsp_err, mem_req, mem_we, mem_be},
            64'd0);
        chk("reset mem_addr", 64'(mem_addr), 64'd0);
        chk("reset mem_wdata", 64'(mem_wdata), 64'd0);
        chk("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Stray ack while idle must not move the controller.
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("stray ack idle", {req_ready, rsp_valid, mem_req}, 64'b100);

        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // Wait states: ack held low for 5 cycles on an aligned lw.
        accept(1'b0, 3'b010, 32'h20, 32'h0, "ws");
        sa = mem_addr; sb = mem_be; sw = mem_wdata;
        chk("ws mem_addr", 64'(sa), 64'h8);
        chk("ws mem_be", 64'(sb), 64'hF);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("ws hold%0d", c), {mem_req, mem_we, rsp_valid, mem_addr, mem_be,
                mem_wdata}, {1'b1, 1'b0, 1'b0, sa, sb, sw});
            @(posedge clk); #1;
        end
        mem_rdata = 32'h12345678;
        mem_ack = 1'b1;
        chk("ws no early rsp", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("ws rsp_valid", 64'(rsp_valid), 64'd1);
        chk("ws rsp_rdata", 64'(rsp_rdata), 64'h12345678);
        @(posedge clk); #1;
        chk("ws rsp one cycle", 64'(rsp_valid), 64'd0);

        // Reset while a beat is waiting for ack.
`ifdef LSU_MISALIGN_SPLIT_EN
        accept(1'b0, 3'b010, 32'h0E, 32'h0, "rst");
        mem_rdata = 32'hAABB0000;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        chk("rst in beat1", {mem_req, mem_addr}, {1'b1, 30'h4});
        @(posedge clk); #1;
`else
        accept(1'b0, 3'b010, 32'h20, 32'h0, "rst");
        @(posedge clk); #1;
        chk("rst in beat0", 64'(mem_req), 64'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("rst drops mem_req", 64'(mem_req), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid || mem_req) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("rst no rsp after", 64'(seen), 64'd0);
        chk("rst ready after", 64'(req_ready), 64'd1);
        run_vec(idx_lh);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
